inv_trim_sequencer: RTL and testbench

Sequences the closed-loop trim of the up/down inverter pair's 4-bit PMOS/NMOS configuration codes. On a START request it runs a PMOS phase and then an NMOS phase. Each phase is a linear search driven by the comparator feedback O_INVU/O_INVD, with a settle interval before every sample. It then reports lock, saturation or fault with a BUSY/DONE handshake. It replaces free-running per-clock stepping and sits between the analog trim cell and system control.

---
 rtl/inv_trim_sequencer.sv | 170 +++++++++++++++++
 tb/tb_inv_trim_sequencer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/inv_trim_sequencer.sv
// Closed-loop trim sequencer for the up/down inverter pair: linear search on the PMOS
// code, then the NMOS code, driven by synchronized comparator feedback.
module inv_trim_sequencer #(
  parameter int CONF_BITS     = 4,
  parameter int SETTLE_CYCLES = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 o_invu,
  input  logic                 o_invd,
  output logic [CONF_BITS-1:0] invu_pconf,
  output logic [CONF_BITS-1:0] invu_nconf,
  output logic [CONF_BITS-1:0] invd_pconf,
  output logic [CONF_BITS-1:0] invd_nconf,
  output logic                 busy,
  output logic                 done,
  output logic                 locked,
  output logic                 sat_p,
  output logic                 sat_n,
  output logic                 fault,
  output logic [CONF_BITS+1:0] step_cnt
);

  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, P_SETTLE, P_SAMPLE, N_SETTLE, N_SAMPLE, FIN, ERR
  } state_t;

  state_t               state, state_nx;
  logic [1:0]           sync_u, sync_d;
  logic [7:0]           settle, settle_nx;
  logic                 hist_valid, hist_valid_nx, hist_dec, hist_dec_nx;
  logic [CONF_BITS-1:0] pconf_nx, nconf_nx, active_code;
  logic [CONF_BITS+1:0] cnt_nx;
  logic                 busy_nx, done_nx, locked_nx, sat_p_nx, sat_n_nx, fault_nx;
  logic [1:0]           fb;
  logic                 req_dec, fb_bad, reversal, at_limit;

  assign fb          = {sync_u[1], sync_d[1]};
  assign req_dec     = (fb == 2'b10);
  assign fb_bad      = (fb[1] == fb[0]);
  assign active_code = (state == N_SAMPLE) ? invu_nconf : invu_pconf;
  assign reversal    = hist_valid && (hist_dec != req_dec);
  assign at_limit    = req_dec ? (active_code == '0) : (active_code == '1);

  assign invd_pconf = ~invu_pconf;
  assign invd_nconf = ~invu_nconf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_u <= '0;
      sync_d <= '0;
    end else begin
      sync_u <= {sync_u[0], o_invu};
      sync_d <= {sync_d[0], o_invd};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      settle     <= '0;
      hist_valid <= 1'b0;
      hist_dec   <= 1'b0;
      invu_pconf <= '1;
      invu_nconf <= '1;
      step_cnt   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      locked     <= 1'b0;
      sat_p      <= 1'b0;
      sat_n      <= 1'b0;
      fault      <= 1'b0;
    end else begin
      state      <= state_nx;
      settle     <= settle_nx;
      hist_valid <= hist_valid_nx;
      hist_dec   <= hist_dec_nx;
      invu_pconf <= pconf_nx;
      invu_nconf <= nconf_nx;
      step_cnt   <= cnt_nx;
      busy       <= busy_nx;
      done       <= done_nx;
      locked     <= locked_nx;
      sat_p      <= sat_p_nx;
      sat_n      <= sat_n_nx;
      fault      <= fault_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    settle_nx     = settle;
    hist_valid_nx = hist_valid;
    hist_dec_nx   = hist_dec;
    pconf_nx      = invu_pconf;
    nconf_nx      = invu_nconf;
    cnt_nx        = step_cnt;
    busy_nx       = busy;
    done_nx       = 1'b0;
    locked_nx     = locked;
    sat_p_nx      = sat_p;
    sat_n_nx      = sat_n;
    fault_nx      = fault;

    case (state)
      IDLE: begin
        if (start) begin
          pconf_nx      = '1;
          nconf_nx      = '1;
          locked_nx     = 1'b0;
          sat_p_nx      = 1'b0;
          sat_n_nx      = 1'b0;
          fault_nx      = 1'b0;
          cnt_nx        = '0;
          hist_valid_nx = 1'b0;
          busy_nx       = 1'b1;
          settle_nx     = SETTLE_LOAD;
          state_nx      = P_SETTLE;
        end
      end
      P_SETTLE, N_SETTLE: begin
        if (settle == '0) state_nx = (state == P_SETTLE) ? P_SAMPLE : N_SAMPLE;
        else              settle_nx = settle - 1'b1;
      end
      // A reversal wins over saturation: the search already straddled the trip point.
      P_SAMPLE, N_SAMPLE: begin
        if (fb_bad) begin
          fault_nx = 1'b1;
          state_nx = ERR;
        end else if (reversal || at_limit) begin
          if (!reversal) begin
            if (state == P_SAMPLE) sat_p_nx = 1'b1;
            else                   sat_n_nx = 1'b1;
          end
          if (state == P_SAMPLE) begin
            state_nx      = N_SETTLE;
            settle_nx     = SETTLE_LOAD;
            hist_valid_nx = 1'b0;
          end else begin
            state_nx = FIN;
          end
        end else begin
          if (state == P_SAMPLE) pconf_nx = req_dec ? invu_pconf - 1'b1 : invu_pconf + 1'b1;
          else                   nconf_nx = req_dec ? invu_nconf - 1'b1 : invu_nconf + 1'b1;
          if (step_cnt != '1) cnt_nx = step_cnt + 1'b1;
          hist_valid_nx = 1'b1;
          hist_dec_nx   = req_dec;
          settle_nx     = SETTLE_LOAD;
          state_nx      = (state == P_SAMPLE) ? P_SETTLE : N_SETTLE;
        end
      end
      FIN: begin
        locked_nx = !sat_p && !sat_n;
        done_nx   = 1'b1;
        busy_nx   = 1'b0;
        state_nx  = IDLE;
      end
      ERR: begin
        done_nx  = 1'b1;
        busy_nx  = 1'b0;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_inv_trim_sequencer.sv
// Self-checking bench for inv_trim_sequencer: a run-level trajectory model plus a
// comparator plant, compared every cycle, with literal pins on key results.
module tb_inv_trim_sequencer;

  localparam int S    = 4;
  localparam int MAXT = 128;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       o_invu = 1'b0;
  logic       o_invd = 1'b0;
  logic [3:0] invu_pconf, invu_nconf, invd_pconf, invd_nconf;
  logic       busy, done, locked, sat_p, sat_n, fault;
  logic [5:0] step_cnt;

  int tests_run = 0;
  int tests_failed = 0;
  int mode = 0;
  int run_t = -1;
  int run_len = 0;
  int done_seen = 0;
  int first_step = -1;
  int last_step = -1;
  int n = 0;

  logic [3:0] m_p[MAXT], m_n[MAXT];
  logic [5:0] m_cnt[MAXT];
  logic       m_busy[MAXT], m_done[MAXT], m_locked[MAXT], m_satp[MAXT], m_satn[MAXT], m_fault[MAXT];
  int         m_phase[MAXT];

  logic [3:0] e_p, e_n;
  logic [5:0] e_cnt;
  logic       e_busy, e_done, e_locked, e_satp, e_satn, e_fault;
  int         e_phase;

  inv_trim_sequencer #(.CONF_BITS(4), .SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .o_invu(o_invu), .o_invd(o_invd),
    .invu_pconf(invu_pconf), .invu_nconf(invu_nconf),
    .invd_pconf(invd_pconf), .invd_nconf(invd_nconf),
    .busy(busy), .done(done), .locked(locked), .sat_p(sat_p), .sat_n(sat_n),
    .fault(fault), .step_cnt(step_cnt)
  );

  always #5 clk = ~clk;

  // Analog trim cell stand-in: mode 0 trips at P=9 / N=5, mode 1 always "go up", mode 2 invalid.
  function automatic logic [1:0] plant(input int m, input int ph, input logic [3:0] p, input logic [3:0] nc);
    case (m)
      0:       return (ph == 0) ? ((p > 4'd9) ? 2'b10 : 2'b01) : ((nc > 4'd5) ? 2'b10 : 2'b01);
      2:       return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  task automatic fill_from(input int t, input logic [3:0] p, input logic [3:0] nc, input logic [5:0] c,
                           input logic b, input logic l, input logic sp, input logic sn, input logic f, input int ph);
    for (int j = t; j < MAXT; j++) begin
      m_p[j] = p; m_n[j] = nc; m_cnt[j] = c; m_busy[j] = b; m_locked[j] = l;
      m_satp[j] = sp; m_satn[j] = sn; m_fault[j] = f; m_phase[j] = ph; m_done[j] = 1'b0;
    end
  endtask

  task automatic build_run(input int m);
    logic [3:0] code[2];
    logic [5:0] cnt;
    logic       sat[2];
    logic       flt;
    logic [1:0] f;
    int         t, ph;
    bit         have_prev, prev_dec, dec, done_ph;
    code[0] = 4'hF; code[1] = 4'hF; sat[0] = 1'b0; sat[1] = 1'b0;
    cnt = '0; flt = 1'b0; t = 0; ph = 0;
    fill_from(0, 4'hF, 4'hF, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    while (ph < 2 && !flt) begin
      have_prev = 0; prev_dec = 0; done_ph = 0;
      while (!done_ph && t < MAXT - S - 3) begin
        t += S + 1;
        f = plant(m, ph, code[0], code[1]);
        if (f == 2'b00 || f == 2'b11) begin
          flt = 1'b1; done_ph = 1;
        end else begin
          dec = (f == 2'b10);
          if (have_prev && prev_dec != dec) done_ph = 1;
          else if (dec ? code[ph] == 4'd0 : code[ph] == 4'hF) begin
            sat[ph] = 1'b1; done_ph = 1;
          end else begin
            code[ph] = dec ? code[ph] - 4'd1 : code[ph] + 4'd1;
            if (cnt != 6'd63) cnt++;
            have_prev = 1; prev_dec = dec;
          end
        end
        fill_from(t, code[0], code[1], cnt, 1'b1, 1'b0, sat[0], sat[1], flt, (done_ph && !flt) ? 1 : ph);
      end
      ph++;
    end
    run_len = t + 1;
    fill_from(t + 1, code[0], code[1], cnt, 1'b0, !flt && !sat[0] && !sat[1], sat[0], sat[1], flt, 1);
    m_done[t + 1] = 1'b1;
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) run_t = -1;
      else if (start && (run_t < 0 || run_t >= run_len)) begin
        build_run(mode);
        run_t = 0;
      end else if (run_t >= 0 && run_t < MAXT - 1) run_t++;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (run_t < 0) begin
        e_p = 4'hF; e_n = 4'hF; e_cnt = '0; e_busy = 0; e_done = 0; e_locked = 0;
        e_satp = 0; e_satn = 0; e_fault = 0; e_phase = 0;
      end else begin
        e_p = m_p[run_t]; e_n = m_n[run_t]; e_cnt = m_cnt[run_t]; e_busy = m_busy[run_t];
        e_done = m_done[run_t]; e_locked = m_locked[run_t]; e_satp = m_satp[run_t];
        e_satn = m_satn[run_t]; e_fault = m_fault[run_t]; e_phase = m_phase[run_t];
      end
      {o_invu, o_invd} = plant(mode, e_phase, e_p, e_n);
      if (done === 1'b1) done_seen++;
      if (run_t >= 0 && step_cnt == 6'd1 && first_step < 0) first_step = run_t;
      if (run_t >= 0 && step_cnt == 6'd16 && last_step < 0) last_step = run_t;
      tests_run++;
      if (invu_pconf !== e_p || invu_nconf !== e_n || invd_pconf !== ~e_p || invd_nconf !== ~e_n ||
          step_cnt !== e_cnt || busy !== e_busy || done !== e_done || locked !== e_locked ||
          sat_p !== e_satp || sat_n !== e_satn || fault !== e_fault) begin
        tests_failed++;
        $display("[TB] FAIL cycle_compare t=%0d got p=%h n=%h dp=%h dn=%h cnt=%0d busy=%b done=%b lock=%b sp=%b sn=%b flt=%b | want p=%h n=%h dp=%h dn=%h cnt=%0d busy=%b done=%b lock=%b sp=%b sn=%b flt=%b",
                 run_t, invu_pconf, invu_nconf, invd_pconf, invd_nconf, step_cnt, busy, done, locked, sat_p, sat_n, fault,
                 e_p, e_n, ~e_p, ~e_n, e_cnt, e_busy, e_done, e_locked, e_satp, e_satn, e_fault);
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int m);
    @(negedge clk);
    mode = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDone(input int budget, output int cycles);
    cycles = 0;
    while (done !== 1'b1 && cycles < budget) begin
      @(negedge clk);
      cycles++;
    end
    if (done !== 1'b1) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL done_timeout: got no DONE within %0d cycles, expected a pulse", budget);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish by 200000 ns, expected earlier");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("rst_pconf", invu_pconf, 15);
    checkOutput("rst_nconf", invu_nconf, 15);
    checkOutput("rst_dpconf", invd_pconf, 0);
    checkOutput("rst_dnconf", invd_nconf, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_flags", {done, locked, sat_p, sat_n, fault}, 0);
    checkOutput("rst_cnt", step_cnt, 0);
    start = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("post_rst_idle_busy", busy, 0);

    done_seen = 0; first_step = -1; last_step = -1;
    applyStimulus(0);
    waitDone(150, n);
    checkOutput("main_done_latency", n, 91);
    checkOutput("main_dpconf", invd_pconf, 6);
    checkOutput("main_dnconf", invd_nconf, 10);
    checkOutput("main_cnt", step_cnt, 16);
    checkOutput("main_locked", locked, 1);
    checkOutput("main_sat", {sat_p, sat_n}, 0);
    checkOutput("main_busy", busy, 0);
    repeat (3) @(negedge clk);
    checkOutput("main_done_pulses", done_seen, 1);
    checkOutput("main_first_step_t", first_step, 5);
    checkOutput("main_last_step_t", last_step, 85);

    applyStimulus(1);
    waitDone(50, n);
    checkOutput("sat_done_latency", n, 11);
    checkOutput("sat_flags", {sat_p, sat_n, locked}, 3'b110);
    checkOutput("sat_cnt", step_cnt, 0);
    checkOutput("sat_codes", {invu_pconf, invu_nconf, invd_pconf, invd_nconf}, 16'hFF00);

    applyStimulus(2);
    waitDone(50, n);
    checkOutput("fault_done_latency", n, 6);
    checkOutput("fault_flag", fault, 1);
    checkOutput("fault_busy", busy, 0);
    checkOutput("fault_codes", {invu_pconf, invu_nconf, invd_pconf, invd_nconf}, 16'hFF00);
    applyStimulus(1);
    checkOutput("fault_cleared", fault, 0);
    checkOutput("restart_busy", busy, 1);
    waitDone(50, n);
    checkOutput("restart_done_latency", n, 11);

    applyStimulus(1);
    n = 0;
    while (done !== 1'b1 && n < 50) begin
      start = (n == 1 || n == 4 || n == 7 || n == 10);
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    checkOutput("busy_start_done_latency", n, 11);
    checkOutput("busy_start_flags", {sat_p, sat_n, locked, fault}, 4'b1100);
    checkOutput("busy_start_cnt", step_cnt, 0);
    repeat (3) @(negedge clk);
    checkOutput("busy_start_idle", busy, 0);

    applyStimulus(0);
    repeat (45) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_codes", {invu_pconf, invu_nconf, invd_pconf, invd_nconf}, 16'hFF00);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_cnt", step_cnt, 0);
    checkOutput("midrst_flags", {done, locked, sat_p, sat_n, fault}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(0);
    waitDone(150, n);
    checkOutput("rerun_done_latency", n, 91);
    checkOutput("rerun_codes", {invd_pconf, invd_nconf}, 8'h6A);
    checkOutput("rerun_cnt", step_cnt, 16);
    checkOutput("rerun_locked", locked, 1);
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
